sw_rr_arbiter: RTL and testbench
================================

// Module: sw_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one indicator/output resource (the LED gate path) among N switch requesters.
//  Each requester holds its switch high to request. The block grants one owner at a time and drives a one-hot LED grant vector.
//  It bounds each grant to HOLD_CYC cycles so that no switch can starve the others.
//  Sits between the board switch inputs and the LED/gate logic; one instance per shared resource.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  HOLD_CYC  8   maximum consecutive cycles of a single grant (>=1)
//  DB_CYC    4   stable cycles required by the debouncer (used only with DEBOUNCE_EN)
// PORTS
//  clk    in   1              system clock, all state on rising edge
//  reset  in   1              asynchronous, active-high reset
//  Sw     in   N              level request per requester, bit i = requester i
//  LED    out  N              one-hot grant; all zero when no grant
//  Busy   out  1              high while a grant is active (LED != 0)
//  Owner  out  $clog2(N)      index of current/last owner
// BEHAVIOUR
//  Reset (async, immediate): LED=0, Busy=0, Owner=0, ptr=0, hold counter=0, state=IDLE.
//  Internal req = Sw (or debounced Sw, see CONFIGURATION).
//  State machine (registered states IDLE, GRANT, RELEASE):
//   IDLE    -> GRANT if req != 0. Winner = first set bit of req searched from ptr upward, wrapping N-1 -> 0.
//              On entry to GRANT: Owner = winner, LED = one-hot(winner), Busy = 1, counter = 0.
//   GRANT   -> counter increments each cycle. If req[Owner]==0 OR counter==HOLD_CYC-1: -> RELEASE.
//              On entry to RELEASE: LED = 0, Busy = 0.
//   RELEASE -> always IDLE after 1 cycle. ptr = (Owner+1) mod N. Owner keeps its value.
//  Latency: request in IDLE -> LED high on the next clock edge (1 cycle).
//  Grant length: min(request duration, HOLD_CYC) cycles.
//  Re-arbitration gap: 2 cycles with LED=0 (RELEASE + IDLE) between consecutive grants.
//  Boundary conditions:
//   - Requests from non-owners during GRANT are ignored until IDLE. No preemption.
//   - An owner still requesting at forced release is eligible again only after others: ptr has advanced past it.
//   - A lone requester at forced release is re-granted after the 2-cycle gap.
//   - All requests drop in IDLE: remain IDLE, outputs stay 0.
//   - Owner drops and re-raises within RELEASE/IDLE: treated as a new request, subject to ptr order.
//   - ptr wraps N-1 -> 0. Owner width is $clog2(N); non-power-of-2 N must never produce an index >= N.
//   - Counter width is $clog2(HOLD_CYC+1) and never wraps (cleared on GRANT entry).
//   - Reset asserted mid-grant: LED drops asynchronously. After reset, ptr=0, so search restarts at requester 0.
//  LED is never multi-hot. Busy == |LED at all times.
// CONFIGURATION
//  DEBOUNCE_EN defined:
//   - Each Sw bit passes through a 2-FF synchronizer.
//   - Internal req[i] changes only after the synchronized value has been stable for DB_CYC consecutive cycles.
//   - Added request latency is 2+DB_CYC cycles. Debouncer state resets to 0.
//  DEBOUNCE_EN undefined:
//   - req = Sw directly. Sw must be synchronous to clk. DB_CYC is unused. No added latency.
// TESTING (N=4, HOLD_CYC=8, DB_CYC=4; DEBOUNCE_EN off unless noted)
//  1. Assert reset with Sw=1111 -> LED=0000, Busy=0, Owner=0 immediately, held while reset high.
//  2. Sw=0010 at edge k, dropped at k+3 -> LED=0010 / Owner=1 / Busy=1 at k+1..k+3; LED=0000 at k+4.
//  3. Sw=1111 held -> grants owner 0,1,2,3,0 in order, each LED-high 8 cycles, 2 zero cycles between (period 10).
//  4. Owner 3 released, Sw=1001 -> next grant Owner=0 (ptr wrap). Owner 3 is served only after 0.
//  5. Reset pulsed during Owner=2 grant, then Sw=0110 -> LED drops at once; next grant Owner=1 (ptr=0).
//  6. DEBOUNCE_EN: 1-cycle pulse on Sw[0] -> no grant. Sw[0] held high -> LED=0001 exactly 2+4+1=7 cycles after rise.

Source files
------------

// File: rtl/sw_rr_arbiter_if.sv
// Switch/LED bundle for sw_rr_arbiter.
// master = switch side (drives Sw); slave = arbiter (drives LED/Busy/Owner).
interface sw_rr_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = $clog2(N);

  logic [N-1:0]  Sw;
  logic [N-1:0]  LED;
  logic          Busy;
  logic [OW-1:0] Owner;

  modport master (output Sw, input LED, input Busy, input Owner);
  modport slave  (input Sw, output LED, output Busy, output Owner);
endinterface

// File: rtl/sw_rr_arbiter.sv
// Round-robin arbiter sharing one LED/gate resource among N switch requesters.
// Each grant lasts at most HOLD_CYC cycles and is followed by a 2-cycle gap.
// Optional macro DEBOUNCE_EN: 2-FF synchronizer plus a DB_CYC-cycle stability
// filter on each switch before arbitration.
module sw_rr_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_CYC = 8,
  parameter int DB_CYC   = 4
) (
  input  logic           clk,
  input  logic           reset,
  sw_rr_arbiter_if.slave bus
);
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(HOLD_CYC + 1);

  // Elaboration-time sanity checks on the configuration.
  if (N < 2)        begin : g_chk_n    $error("N must be >= 2");        end
  if (HOLD_CYC < 1) begin : g_chk_hold $error("HOLD_CYC must be >= 1"); end
  if (DB_CYC < 1)   begin : g_chk_db   $error("DB_CYC must be >= 1");   end

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  logic [N-1:0] req;

`ifdef DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYC + 1);

  logic [N-1:0]   sync1, sync2, req_q;
  logic [DBW-1:0] dbc [N];

  // Synchronize each switch, then accept a new level only after it has
  // differed from the current request for DB_CYC consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      req_q <= '0;
      for (int i = 0; i < N; i++) dbc[i] <= '0;
    end else begin
      sync1 <= bus.Sw;
      sync2 <= sync1;
      for (int i = 0; i < N; i++) begin
        if (sync2[i] != req_q[i]) begin
          if (dbc[i] == DBW'(DB_CYC - 1)) begin
            req_q[i] <= sync2[i];
            dbc[i]   <= '0;
          end else begin
            dbc[i] <= dbc[i] + 1'b1;
          end
        end else begin
          dbc[i] <= '0;
        end
      end
    end
  end

  assign req = req_q;
`else
  assign req = bus.Sw;
`endif

  // First set bit of r at or above p, wrapping N-1 -> 0; returns p when r == 0.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] w;
    logic [OW-1:0] ix;
    logic          found;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      ix = OW'((int'(p) + i) % N);
      if (!found && r[ix]) begin
        w     = ix;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  state_t        state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] owner_q;
  logic [CW-1:0] cnt;
  logic [N-1:0]  led_q;
  logic          busy_q;
  logic [OW-1:0] winner;

  assign winner = rr_pick(req, ptr);

  // Grant FSM with registered LED/Busy/Owner; the search pointer moves one
  // past the owner on release so a persistent owner goes to the back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner_q <= '0;
      cnt     <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner_q <= winner;
            led_q   <= {{(N-1){1'b0}}, 1'b1} << winner;
            busy_q  <= 1'b1;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          cnt <= cnt + 1'b1;
          if (!req[owner_q] || cnt == CW'(HOLD_CYC - 1)) begin
            led_q  <= '0;
            busy_q <= 1'b0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          ptr   <= (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.LED   = led_q;
  assign bus.Busy  = busy_q;
  assign bus.Owner = owner_q;
endmodule

// File: tb/tb_sw_rr_arbiter.sv
// Self-checking bench for sw_rr_arbiter (N=4, HOLD_CYC=8, DB_CYC=4).
module tb_sw_rr_arbiter;
  localparam int N    = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset;

  sw_rr_arbiter_if #(.N(N)) bus ();

  sw_rr_arbiter #(.N(N), .HOLD_CYC(HOLD), .DB_CYC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks how many cycles the current grant has lasted
  // and how many idle edges must pass before the next arbitration.
  int m_busy, m_owner, m_len, m_gap, m_ptr;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_len = 0; m_gap = 0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [N-1:0] sw);
    int k;
    bit found;
    if (m_busy != 0) begin
      if (!sw[m_owner] || m_len == HOLD) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
        m_gap  = 1;
      end else begin
        m_len++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (sw != '0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && sw[k]) begin
          m_owner = k;
          found = 1;
        end
      end
      m_busy = 1;
      m_len  = 1;
    end
  endtask

  // Apply Sw, take one rising edge, advance the model, sample 1 time unit later.
  task automatic cycle(input logic [N-1:0] sw);
    bus.Sw = sw;
    @(posedge clk);
    model_step(sw);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.Sw = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] sw;
    logic [N-1:0] led;
    logic [1:0]   owner;
    logic         busy;
  } vec_t;

  vec_t tbl [16];
  logic [N-1:0] rsw;
  logic [N-1:0] exp_led;

  initial begin
    reset  = 1'b1;
    bus.Sw = '0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led",   32'(bus.LED),   0);
    chk("reset_busy",  32'(bus.Busy),  0);
    chk("reset_owner", 32'(bus.Owner), 0);
    reset = 1'b0;

    // Test 1: reset asserted mid-grant with all switches up.
    cycle(4'b1111);
    cycle(4'b1111);
    chk("t1_pre_led", 32'(bus.LED), 32'h1);
    reset = 1'b1;
    #1;
    chk("t1_async_led",   32'(bus.LED),   0);
    chk("t1_async_busy",  32'(bus.Busy),  0);
    chk("t1_async_owner", 32'(bus.Owner), 0);
    for (int i = 0; i < 2; i++) begin
      cycle(4'b1111);
      chk("t1_held_led", 32'(bus.LED), 0);
    end
    do_reset();

`ifdef DEBOUNCE_EN
    // Test 6: one-cycle pulse is filtered out.
    cycle(4'b0001);
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0000);
      chk("t6_pulse_led", 32'(bus.LED), 0);
    end
    // Held switch: grant appears on the 7th edge after the rise.
    for (int i = 1; i <= 10; i++) begin
      cycle(4'b0001);
      chk("t6_held_led", 32'(bus.LED), (i >= 7) ? 32'h1 : 32'h0);
    end
`else
    // Table: short grant, wrap of the search pointer, lone requester.
    tbl[0]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[1]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[2]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[6]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[7]  = '{4'b0001, 4'b0000, 2'd3, 1'b0};
    tbl[8]  = '{4'b1001, 4'b0000, 2'd3, 1'b0};
    tbl[9]  = '{4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[10] = '{4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[12] = '{4'b1000, 4'b0000, 2'd0, 1'b0};
    tbl[13] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[15] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].sw);
      chk($sformatf("tbl%0d_led", i),   32'(bus.LED),   32'(tbl[i].led));
      chk($sformatf("tbl%0d_owner", i), 32'(bus.Owner), 32'(tbl[i].owner));
      chk($sformatf("tbl%0d_busy", i),  32'(bus.Busy),  32'(tbl[i].busy));
    end

    // Test 3: all requesting -> owners 0,1,2,3,0 with period 10.
    do_reset();
    for (int c = 0; c < 50; c++) begin
      cycle(4'b1111);
      exp_led = ((c % 10) < 8) ? (4'b0001 << ((c / 10) % 4)) : 4'b0000;
      chk("t3_led",   32'(bus.LED),   32'(exp_led));
      chk("t3_owner", 32'(bus.Owner), 32'((c / 10) % 4));
    end

    // Test 5: reset during owner 2 grant, then search restarts at 0.
    do_reset();
    cycle(4'b0100);
    cycle(4'b0100);
    chk("t5_owner2", 32'(bus.Owner), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_led", 32'(bus.LED), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(4'b0110);
    chk("t5_led",   32'(bus.LED),   32'h2);
    chk("t5_owner", 32'(bus.Owner), 1);

    // Randomized run against the reference model.
    do_reset();
    rsw = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) rsw = N'($urandom);
      cycle(rsw);
      exp_led = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("rnd_led",   32'(bus.LED),   32'(exp_led));
      chk("rnd_busy",  32'(bus.Busy),  32'(m_busy));
      chk("rnd_owner", 32'(bus.Owner), 32'(m_owner));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
